// File: rtl/ula_multicycle.sv
// Handshaked ALU: single-cycle add/sub/logic/shift/slt, plus an optional iterative
// shift-add multiplier enabled by defining ULA_MUL_EN (op 8 is undefined otherwise).
module ula_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               op,
   input  logic signed [WIDTH-1:0]  a,
   input  logic signed [WIDTH-1:0]  b,
   input  logic [SHAMT_W-1:0]       shamt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         result,
   output logic                     overflow,
   output logic                     busy
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRL = 4'd5;
   localparam logic [3:0] OP_SRA = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_XOR = 4'd9;
   localparam logic [3:0] OP_NOR = 4'd10;
`ifdef ULA_MUL_EN
   localparam logic [3:0]         OP_MUL   = 4'd8;
   localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q;
   logic               ovf_q;
   logic               accept;

   // Returns {overflow, result} for every op that completes in one cycle.
   function automatic logic [WIDTH:0] alu_simple(input logic [3:0]              f_op,
                                                 input logic signed [WIDTH-1:0] fa,
                                                 input logic signed [WIDTH-1:0] fb,
                                                 input logic [SHAMT_W-1:0]      fsh);
      logic signed [WIDTH-1:0] r;
      logic signed [WIDTH-1:0] nb;
      logic                    v;
      r  = '0;
      v  = 1'b0;
      nb = ~fb;
      case (f_op)
         OP_ADD: begin
            r = fa + fb;
            v = (fa[WIDTH-1] == fb[WIDTH-1]) && (r[WIDTH-1] != fa[WIDTH-1]);
         end
         OP_SUB: begin
            r = fa - fb;
            v = (fa[WIDTH-1] == nb[WIDTH-1]) && (r[WIDTH-1] != fa[WIDTH-1]);
         end
         OP_AND: r = fa & fb;
         OP_OR:  r = fa | fb;
         OP_XOR: r = fa ^ fb;
         OP_NOR: r = ~(fa | fb);
         OP_SLL: r = fa << fsh;
         OP_SRL: r = fa >> fsh;
         OP_SRA: r = fa >>> fsh;
         OP_SLT: r = {{(WIDTH-1){1'b0}}, (fa < fb)};
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   assign accept = in_valid & in_ready;

`ifdef ULA_MUL_EN
   logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
   logic [WIDTH-1:0]   mplier_q;
   logic [SHAMT_W-1:0] cnt_q;

   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Multiplier consumes one bit of b per cycle, multiplicand doubles alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (accept && (op == OP_MUL)) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         cnt_q    <= '0;
      end else if (state_q == S_EXEC) begin
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ULA_MUL_EN
               state_d = (op == OP_MUL) ? S_EXEC : S_DONE;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef ULA_MUL_EN
         S_EXEC: if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
   end

   // Result only moves on acceptance or on the final multiply step, so it is stable in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
`ifdef ULA_MUL_EN
         if (op != OP_MUL) {ovf_q, result_q} <= alu_simple(op, a, b, shamt);
`else
         {ovf_q, result_q} <= alu_simple(op, a, b, shamt);
`endif
      end
`ifdef ULA_MUL_EN
      else if ((state_q == S_EXEC) && (cnt_q == CNT_LAST)) begin
         result_q <= acc_nxt[WIDTH-1:0];
         ovf_q    <= |acc_nxt[2*WIDTH-1:WIDTH];
      end
`endif
   end

   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ula_multicycle.sv
// Bench for ula_multicycle: directed literal cases plus randomized traffic against a
// transaction-level reference model; adapts to ULA_MUL_EN.
module tb_ula_multicycle;
   localparam int W  = 32;
   localparam int SW = 5;
`ifdef ULA_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [3:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [SW-1:0] shamt = '0;
   logic          in_ready, out_valid, overflow, busy;
   logic [W-1:0]  result;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ula_multicycle #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow), .busy(busy)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic on wide integers, {overflow, result}.
   function automatic logic [W:0] ref_op(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic [SW-1:0] s);
      longint      sx, sy, t;
      logic [63:0] p;
      logic [W-1:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         4'd0: begin t = sx + sy; r = W'(t); return {(t > 64'sd2147483647 || t < -64'sd2147483648), r}; end
         4'd1: begin t = sx - sy; r = W'(t); return {(t > 64'sd2147483647 || t < -64'sd2147483648), r}; end
         4'd2: return {1'b0, x & y};
         4'd3: return {1'b0, x | y};
         4'd4: return {1'b0, x << s};
         4'd5: return {1'b0, x >> s};
         4'd6: begin r = $signed(x) >>> s; return {1'b0, r}; end
         4'd7: return {1'b0, W'($signed(x) < $signed(y))};
         4'd8: begin
            if (!MUL_EN) return '0;
            p = {32'b0, x} * {32'b0, y};
            return {(p[63:32] != 0), p[31:0]};
         end
         4'd9:  return {1'b0, x ^ y};
         4'd10: return {1'b0, ~(x | y)};
         default: return '0;
      endcase
   endfunction

   // Transaction model: one outstanding op, visible after its latency, retired on out_ready.
   logic         m_have = 1'b0;
   int           cyc = 0;
   int           m_ready_at = 0;
   logic [W-1:0] m_res = '0;
   logic         m_ovf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_have     <= 1'b0;
         cyc        <= 0;
         m_ready_at <= 0;
         m_res      <= '0;
         m_ovf      <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (m_have && (cyc >= m_ready_at)) begin
            if (out_ready) m_have <= 1'b0;
         end else if (!m_have && in_valid) begin
            m_have            <= 1'b1;
            m_ready_at        <= cyc + 1 + ((MUL_EN && op == 4'd8) ? W : 0);
            {m_ovf, m_res}    <= ref_op(op, a, b, shamt);
         end
      end
   end

   always @(negedge clk) begin
      logic exp_ov;
      if (rst_n) begin
         exp_ov = m_have && (cyc >= m_ready_at);
         chk("out_valid", W'(out_valid), W'(exp_ov));
         chk("in_ready", W'(in_ready), W'(!m_have));
         chk("busy", W'(busy), W'(m_have));
         if (exp_ov) begin
            chk("result", result, m_res);
            chk("overflow", W'(overflow), W'(m_ovf));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) chk("wait_in_ready", W'(in_ready), W'(1));
   endtask

   task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SW-1:0] s,
                         input logic [W-1:0] er, input logic eo, input int el);
      int n;
      @(negedge clk);
      wait_idle();
      op = o; a = x; b = y; shamt = s; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk({name, " latency"}, W'(n), W'(el));
      chk({name, " result"}, result, er);
      chk({name, " overflow"}, W'(overflow), W'(eo));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", W'(out_valid), W'(0));
      chk("rst in_ready", W'(in_ready), W'(1));
      chk("rst busy", W'(busy), W'(0));
      chk("rst result", result, 32'h0);
      chk("rst overflow", W'(overflow), W'(0));
      rst_n = 1'b1;

      run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 0);
      run_op("add_neg", 4'd0, 32'h5, 32'hFFFF_FFFD, 5'd0, 32'h2, 1'b0, 0);
      run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1, 0);
      run_op("sll", 4'd4, 32'h8000_0010, 32'h0, 5'd4, 32'h0000_0100, 1'b0, 0);
      run_op("srl", 4'd5, 32'h8000_0010, 32'h0, 5'd4, 32'h0800_0001, 1'b0, 0);
      run_op("sra", 4'd6, 32'h8000_0010, 32'h0, 5'd4, 32'hF800_0001, 1'b0, 0);
      run_op("sra0", 4'd6, 32'h8000_0010, 32'h0, 5'd0, 32'h8000_0010, 1'b0, 0);
      run_op("slt_t", 4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 0);
      run_op("slt_f", 4'd7, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 0);
      run_op("xor", 4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'hF0F0_F0F0, 1'b0, 0);
      run_op("nor", 4'd10, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 0);
      run_op("undef", 4'd13, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b0, 0);
      if (MUL_EN) begin
         run_op("mul_big", 4'd8, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 1'b1, 32);
         run_op("mul_small", 4'd8, 32'h7, 32'h6, 5'd0, 32'd42, 1'b0, 32);
      end else begin
         run_op("mul_off", 4'd8, 32'h7, 32'h6, 5'd0, 32'h0, 1'b0, 0);
      end

      // Backpressure: result parked while a second request is presented
      @(negedge clk);
      wait_idle();
      op = 4'd1; a = 32'd10; b = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      op = 4'd0; a = 32'd1; b = 32'd1;
      repeat (10) begin
         @(negedge clk);
         chk("bp result", result, 32'd7);
         chk("bp in_ready", W'(in_ready), W'(0));
         chk("bp out_valid", W'(out_valid), W'(1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp release in_ready", W'(in_ready), W'(1));
      chk("bp release out_valid", W'(out_valid), W'(0));
      out_ready = 1'b0;

      // Reset in the middle of a multiply
      @(negedge clk);
      wait_idle();
      op = 4'd8; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", W'(out_valid), W'(0));
      chk("midrst result", result, 32'h0);
      chk("midrst overflow", W'(overflow), W'(0));
      chk("midrst in_ready", W'(in_ready), W'(1));
      chk("midrst busy", W'(busy), W'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_add", 4'd0, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0, 0);

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 2) != 0);
         op        = ($urandom_range(0, 7) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         a         = pick();
         b         = pick();
         shamt     = SW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
